// File: rtl/spram_asym_wide_write_clr.sv
// spram_asym_wide_write_clr
// Asymmetric simple-dual-port RAM. The write port is RATIO = 2**RATIO_LOG2 narrow
// lanes wide and has one enable per lane. The read port returns one narrow word
// with latency 1, or 2 when OUT_REG=1. An optional sequencer zeroes the whole
// array after reset release. While it runs, busy is high and the user ports are
// ignored.
module spram_asym_wide_write_clr #(
   parameter int RD_WIDTH       = 8,
   parameter int RATIO_LOG2     = 1,
   parameter int RD_ADDR_WIDTH  = 11,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1,
   localparam int RATIO         = 1 << RATIO_LOG2,
   localparam int WR_WIDTH      = RD_WIDTH * RATIO,
   localparam int WR_ADDR_WIDTH = RD_ADDR_WIDTH - RATIO_LOG2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     rce,
   input  logic [RD_ADDR_WIDTH-1:0] ra,
   output logic [RD_WIDTH-1:0]      rq,
   output logic                     rvalid,
   input  logic                     wce,
   input  logic [WR_ADDR_WIDTH-1:0] wa,
   input  logic [WR_WIDTH-1:0]      wd,
   input  logic [RATIO-1:0]         wbe,
   output logic                     busy
);

   localparam int DEPTH = 1 << RD_ADDR_WIDTH;
   localparam logic [WR_ADDR_WIDTH-1:0] CNT_LAST = {WR_ADDR_WIDTH{1'b1}};

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   localparam state_t RST_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;

   // Storage. Reads and writes of one address in the same cycle are not
   // arbitrated: a read in the same cycle as a write returns the old word.
   (* no_rw_check = 1 *)
   logic [RD_WIDTH-1:0] mem [0:DEPTH-1];

   state_t                   state_q, state_d;
   logic [WR_ADDR_WIDTH-1:0] cnt_q, cnt_d;

   // Final write-port controls after the clear sequencer and the user port are merged.
   logic [RATIO-1:0]         mem_we;
   logic [WR_ADDR_WIDTH-1:0] mem_wa;
   logic [WR_WIDTH-1:0]      mem_wd;

   logic                     rd_fire;
   logic [RD_WIDTH-1:0]      rq_q1;
   logic                     rvalid_q1;

   // Narrow-word address of lane 'lane' inside wide word 'w'. Lane 0 is the lowest address.
   function automatic logic [RD_ADDR_WIDTH-1:0] lane_addr(
      input logic [WR_ADDR_WIDTH-1:0] w,
      input int                       lane
   );
      lane_addr = (RD_ADDR_WIDTH'(w) << RATIO_LOG2) | RD_ADDR_WIDTH'(lane);
   endfunction

   assign busy    = (state_q == CLEAR);
   assign rd_fire = rce & ~busy;

   // State register and clear counter. Reset aborts any clear in progress.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= RST_STATE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic. CLEAR visits every wide address once, then falls to IDLE.
   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            cnt_d = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Write-port mux. While busy, all lanes of word cnt are zeroed and the user port is ignored.
   // While rst_n is low, cnt is held at 0. Zeroing word 0 during reset is harmless because
   // the sequence that follows clears it again.
   always_comb begin
      mem_we = '0;
      mem_wa = wa;
      mem_wd = wd;
      if (busy) begin
         mem_we = '1;
         mem_wa = cnt_q;
         mem_wd = '0;
      end else if (wce) begin
         mem_we = wbe;
      end
   end

   // Array write, one narrow lane per enable bit.
   // NOTE: the array has no reset branch; a reset would stop RAM inference.
   // Clearing it is the sequencer's job.
   always_ff @(posedge clk) begin
      for (int i = 0; i < RATIO; i++) begin
         if (mem_we[i]) begin
            mem[lane_addr(mem_wa, i)] <= mem_wd[i*RD_WIDTH +: RD_WIDTH];
         end
      end
   end

   // First read stage. rq holds its last value when no read is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rq_q1     <= '0;
         rvalid_q1 <= 1'b0;
      end else begin
         rvalid_q1 <= rd_fire;
         if (rd_fire) begin
            rq_q1 <= mem[ra];
         end
      end
   end

   generate
      if (OUT_REG != 0) begin : g_out_reg
         logic [RD_WIDTH-1:0] rq_q2;
         logic                rvalid_q2;

         // Optional output register. It delays data and valid together by one cycle.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rq_q2     <= '0;
               rvalid_q2 <= 1'b0;
            end else begin
               rvalid_q2 <= rvalid_q1;
               if (rvalid_q1) begin
                  rq_q2 <= rq_q1;
               end
            end
         end

         assign rq     = rq_q2;
         assign rvalid = rvalid_q2;
      end else begin : g_no_out_reg
         assign rq     = rq_q1;
         assign rvalid = rvalid_q1;
      end
   endgenerate

endmodule
